vc_allocator: RTL and testbench

Output virtual-channel allocator for one mesh router built on `noc_params`. It binds each input VC (`PORT_NUM`×`VC_NUM` = 10) holding a HEAD flit to a free downstream VC on the requested output port. It keeps that binding until the packet's TAIL flit has left. It sits between the input-buffer route stage and the switch allocator.

---
 rtl/vc_allocator.sv | 136 +++++++++++++
 tb/tb_vc_allocator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vc_allocator.sv
`default_nettype none
// ============================================================================
// Module      : vc_allocator
// Description : Output virtual-channel allocator for one mesh router.
//               Binds each input VC holding a HEAD flit to a free downstream
//               VC on its requested output port, with one round-robin arbiter
//               per output port. The binding is held until the input VC
//               signals that its TAIL flit has left.
// Ports       :
//   clk           - single clock
//   rst           - asynchronous, active-low reset
//   request_i     - [IVC_NUM] input VC k requests an output VC
//   out_port_i    - [IVC_NUM][3] output port requested by input VC k
//   release_i     - [IVC_NUM] input VC k forwarded its TAIL flit
//   grant_o       - [IVC_NUM] one-cycle pulse, allocation made for VC k
//   vc_new_o      - [IVC_NUM][VC_SIZE] downstream VC bound to input VC k
//   active_o      - [IVC_NUM] input VC k holds an allocation
//   out_vc_busy_o - [IVC_NUM] output VC (port*VC_NUM+vc) is owned
// Revision    : 1.0 - initial release
// ============================================================================
module vc_allocator #(
  parameter  int PORT_NUM = 5,
  parameter  int VC_NUM   = 2,
  localparam int IVC_NUM  = PORT_NUM * VC_NUM,
  localparam int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int IDX_W    = (IVC_NUM > 1) ? $clog2(IVC_NUM) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IVC_NUM-1:0]                request_i,
  input  logic [IVC_NUM-1:0][2:0]           out_port_i,
  input  logic [IVC_NUM-1:0]                release_i,
  output logic [IVC_NUM-1:0]                grant_o,
  output logic [IVC_NUM-1:0][VC_SIZE-1:0]   vc_new_o,
  output logic [IVC_NUM-1:0]                active_o,
  output logic [IVC_NUM-1:0]                out_vc_busy_o
);

  // Per input VC state
  logic [IVC_NUM-1:0]               r_active;
  logic [IVC_NUM-1:0][VC_SIZE-1:0]  r_vc_new;
  logic [IVC_NUM-1:0]               r_grant;
  // Per output VC state
  logic [IVC_NUM-1:0]               r_busy;
  logic [IVC_NUM-1:0][IDX_W-1:0]    r_owner;
  // Per output port round-robin pointer
  logic [PORT_NUM-1:0][IDX_W-1:0]   r_rr;

  logic [IVC_NUM-1:0]               w_elig;
  logic [IVC_NUM-1:0]               w_rel;
  logic [IVC_NUM-1:0]               w_ov_free;
  logic [PORT_NUM-1:0]              w_vc_avail;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] w_free_vc;
  logic [PORT_NUM-1:0]              w_gnt;
  logic [PORT_NUM-1:0][IDX_W-1:0]   w_win;
  logic [PORT_NUM-1:0][IDX_W-1:0]   w_rr_next;

  // Release only counts for an ACTIVE input VC; an output VC frees when its
  // owner releases. Everything below looks at pre-edge state only, so a VC
  // freed this cycle is not offered to a requester until the next cycle.
  always_comb begin
    for (int k = 0; k < IVC_NUM; k++) begin
      w_rel[k]  = release_i[k] & r_active[k];
      w_elig[k] = request_i[k] & ~r_active[k] & (out_port_i[k] < 3'(PORT_NUM));
    end
    for (int o = 0; o < IVC_NUM; o++) begin
      w_ov_free[o] = r_busy[o] & w_rel[r_owner[o]];
    end
  end

  // One arbiter per output port: lowest free VC, first eligible candidate
  // at or after the pointer in cyclic order.
  always_comb begin
    int idx;
    for (int p = 0; p < PORT_NUM; p++) begin
      w_vc_avail[p] = 1'b0;
      w_free_vc[p]  = '0;
      for (int v = VC_NUM - 1; v >= 0; v--) begin
        if (!r_busy[p*VC_NUM + v]) begin
          w_vc_avail[p] = 1'b1;
          w_free_vc[p]  = VC_SIZE'(v);
        end
      end
      w_gnt[p] = 1'b0;
      w_win[p] = '0;
      for (int i = 0; i < IVC_NUM; i++) begin
        idx = int'(r_rr[p]) + i;
        if (idx >= IVC_NUM) idx = idx - IVC_NUM;
        if (w_vc_avail[p] && !w_gnt[p] && w_elig[idx] &&
            (out_port_i[idx] == 3'(p))) begin
          w_gnt[p] = 1'b1;
          w_win[p] = IDX_W'(idx);
        end
      end
      w_rr_next[p] = (int'(w_win[p]) == IVC_NUM - 1) ? '0 : w_win[p] + IDX_W'(1);
    end
  end

  // A grant only targets an IDLE input VC and a FREE output VC, while a
  // release only touches ACTIVE/BUSY ones, so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= '0;
      r_vc_new <= '0;
      r_grant  <= '0;
      r_busy   <= '0;
      r_owner  <= '0;
      r_rr     <= '0;
    end else begin
      r_grant <= '0;
      for (int k = 0; k < IVC_NUM; k++) begin
        if (w_rel[k]) r_active[k] <= 1'b0;
      end
      for (int o = 0; o < IVC_NUM; o++) begin
        if (w_ov_free[o]) r_busy[o] <= 1'b0;
      end
      for (int p = 0; p < PORT_NUM; p++) begin
        if (w_gnt[p]) begin
          r_active[w_win[p]]                         <= 1'b1;
          r_grant[w_win[p]]                          <= 1'b1;
          r_vc_new[w_win[p]]                         <= w_free_vc[p];
          r_busy[p*VC_NUM + int'(w_free_vc[p])]      <= 1'b1;
          r_owner[p*VC_NUM + int'(w_free_vc[p])]     <= w_win[p];
          r_rr[p]                                    <= w_rr_next[p];
        end
      end
    end
  end

  assign grant_o       = r_grant;
  assign vc_new_o      = r_vc_new;
  assign active_o      = r_active;
  assign out_vc_busy_o = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vc_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_allocator
// Description : Self-checking bench for vc_allocator. A table of per-cycle
//               input records with hand-computed expected outputs, followed
//               by a hand-written asynchronous reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_allocator;

  localparam int C = 0, U = 1, D = 2, L = 3, R = 4;

  logic             clk;
  logic             rst;
  logic [9:0]       request;
  logic [9:0][2:0]  out_port;
  logic [9:0]       release_v;
  logic [9:0]       grant;
  logic [9:0][0:0]  vc_new;
  logic [9:0]       active;
  logic [9:0]       busy;

  int n_cmp = 0;
  int n_err = 0;

  vc_allocator dut (
    .clk           (clk),
    .rst           (rst),
    .request_i     (request),
    .out_port_i    (out_port),
    .release_i     (release_v),
    .grant_o       (grant),
    .vc_new_o      (vc_new),
    .active_o      (active),
    .out_vc_busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  req;
    logic [29:0] port;
    logic [9:0]  rel;
    logic [9:0]  eg;   // expected grant_o
    logic [9:0]  ea;   // expected active_o
    logic [9:0]  eb;   // expected out_vc_busy_o
    logic [9:0]  vm;   // vc_new_o bits to check
    logic [9:0]  vv;   // expected vc_new_o under mask
  } vec_t;

  vec_t vecs[32];
  int   n_vec = 0;

  function automatic logic [29:0] sp(input int k, input int p);
    logic [29:0] r;
    logic [2:0]  p3;
    r  = '0;
    p3 = 3'(p);
    r[3*k +: 3] = p3;
    return r;
  endfunction

  function automatic logic [9:0] b(input int k);
    logic [9:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  task automatic add(input logic [9:0] req, input logic [29:0] port,
                     input logic [9:0] rel, input logic [9:0] eg,
                     input logic [9:0] ea, input logic [9:0] eb,
                     input logic [9:0] vm, input logic [9:0] vv);
    vecs[n_vec] = '{req, port, rel, eg, ea, eb, vm, vv};
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    rst       = 1'b0;
    request   = '0;
    out_port  = '0;
    release_v = '0;

    // Single request to RIGHT, release, ignored inputs
    add(b(3), sp(3,R), '0,   b(3), b(3), b(8), b(3), '0);
    add('0,   '0,      '0,   '0,   b(3), b(8), b(3), '0);
    add('0,   '0,      b(3), '0,   '0,   '0,   '0,   '0);
    add(b(5), sp(5,6), b(3), '0,   '0,   '0,   '0,   '0);
    add(b(5), sp(5,6), '0,   '0,   '0,   '0,   '0,   '0);
    // Contention on UP: 0, 4, 7
    add(b(0)|b(4)|b(7), sp(0,U)|sp(4,U)|sp(7,U), '0, b(0), b(0), b(2), b(0), '0);
    add(b(4)|b(7), sp(4,U)|sp(7,U), '0, b(4), b(0)|b(4), b(2)|b(3), b(4), b(4));
    add(b(7), sp(7,U), '0,   '0,   b(0)|b(4), b(2)|b(3), '0, '0);
    add(b(7), sp(7,U), b(4), '0,   b(0),      b(2),      '0, '0);
    add(b(7), sp(7,U), '0,   b(7), b(0)|b(7), b(2)|b(3), b(7), b(7));
    // Request from an ACTIVE VC: no second grant
    add(b(0), sp(0,U), '0,   '0,   b(0)|b(7), b(2)|b(3), '0, '0);
    add('0,   '0,      b(0)|b(7), '0, '0, '0, '0, '0);
    // Round robin on DOWN: grant to 4 leaves the pointer at 5
    add(b(4), sp(4,D), '0, b(4), b(4), b(4), b(4), '0);
    add(b(2)|b(6), sp(2,D)|sp(6,D), '0, b(6), b(4)|b(6), b(4)|b(5), b(6), b(6));
    add(b(2), sp(2,D), b(6), '0, b(4), b(4), '0, '0);
    add(b(2)|b(6), sp(2,D)|sp(6,D), '0, b(2), b(2)|b(4), b(4)|b(5), b(2), b(2));
    add('0, '0, b(2)|b(4), '0, '0, '0, '0, '0);
    // Same-cycle release/request on LEFT
    add(b(1)|b(8), sp(1,L)|sp(8,L), '0, b(1), b(1), b(6), b(1), '0);
    add(b(8), sp(8,L), '0, b(8), b(1)|b(8), b(6)|b(7), b(8), b(8));
    add(b(9), sp(9,L), b(1), '0, b(8), b(7), '0, '0);
    add(b(9), sp(9,L), '0, b(9), b(8)|b(9), b(6)|b(7), b(9), '0);
    // Two ports granted in the same cycle; four VCs now active
    add(b(0)|b(3), sp(0,C)|sp(3,R), '0, b(0)|b(3),
        b(0)|b(3)|b(8)|b(9), b(0)|b(6)|b(7)|b(8), b(0)|b(3), '0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset grant",  grant,  '0);
    chk("reset active", active, '0);
    chk("reset busy",   busy,   '0);
    chk("reset vc_new", vc_new, '0);
    rst = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      request   = vecs[i].req;
      out_port  = vecs[i].port;
      release_v = vecs[i].rel;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d grant", i),  grant,  vecs[i].eg);
      chk($sformatf("row%0d active", i), active, vecs[i].ea);
      chk($sformatf("row%0d busy", i),   busy,   vecs[i].eb);
      chk($sformatf("row%0d vc_new", i), vc_new & vecs[i].vm, vecs[i].vv);
    end
    request   = '0;
    out_port  = '0;
    release_v = '0;

    // Asynchronous reset mid-cycle with four VCs active
    #3;
    rst = 1'b0;
    #1;
    chk("async active", active, '0);
    chk("async busy",   busy,   '0);
    chk("async grant",  grant,  '0);
    chk("async vc_new", vc_new, '0);
    @(posedge clk);
    #1;
    chk("in-reset grant", grant, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("exit grant", grant, '0);

    // Fresh requests to CENTER: pointer back at 0 so k=0 wins first
    request  = b(0) | b(5);
    out_port = sp(0,C) | sp(5,C);
    @(posedge clk);
    #1;
    chk("post grant0",  grant,  b(0));
    chk("post vc0",     vc_new & b(0), '0);
    chk("post busy0",   busy,   b(0));
    request  = b(5);
    out_port = sp(5,C);
    @(posedge clk);
    #1;
    chk("post grant5",  grant,  b(5));
    chk("post vc5",     vc_new & b(5), b(5));
    chk("post busy5",   busy,   b(0) | b(1));
    request = '0;
    @(posedge clk);
    #1;
    chk("post pulse",   grant,  '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
